// File: rtl/clk_period_monitor_pkg.sv
// Shared definitions for the divided-clock period monitor: state encoding and
// default constants derived from the 24 MHz system / 2.4 MHz divided clock pair.
package clk_period_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    localparam int SYS_CLK_HZ = 24_000_000;
    localparam int DIV_CLK_HZ = 2_400_000;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EXP_PERIOD = SYS_CLK_HZ / DIV_CLK_HZ;
    localparam int DEF_TOL        = 1;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_TIMEOUT    = 40;

endpackage

// File: rtl/clk_period_monitor_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge
// detector; Rise is a single-cycle pulse 2-3 cycles after the input edge.
module sync_edge_det (
    input  logic Clk_24M,
    input  logic Rst,
    input  logic Din,
    output logic Rise
);

    logic s1, s2, s3;

    always_ff @(posedge Clk_24M) begin
        if (Rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign Rise = s2 & ~s3;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an externally divided clock in Clk_24M cycles,
// declares lock after a run of in-tolerance periods, and flags errors/stalls.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             Clk_24M,
    input  logic             Rst,
    input  logic             Clk_in,
    output logic [CNT_W-1:0] Period,
    output logic             Period_vld,
    output logic             Locked,
    output logic             Err,
    output logic             Stall
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    // Lower bound clipped at zero so a large TOL cannot underflow the compare.
    localparam int               LO_I    = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam logic [CNT_W:0]   PER_LO  = (CNT_W+1)'(LO_I);
    localparam logic [CNT_W:0]   PER_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam int               GW      = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0]    GOOD_LK = GW'(LOCK_CNT);

    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_p1;
    logic             cnt_sat;
    logic             tmo_hit;
    logic             per_good;
    logic [CNT_W-1:0] per_val;
    logic [GW-1:0]    good_q, good_d, good_inc;
    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] period_d;
    logic             vld_d, locked_d, err_d, stall_d;

    sync_edge_det u_sync (
        .Clk_24M (Clk_24M),
        .Rst     (Rst),
        .Din     (Clk_in),
        .Rise    (rise)
    );

    // Free-running interval counter, restarted by every rising edge.
    always_ff @(posedge Clk_24M) begin
        if (Rst)
            cnt <= '0;
        else if (rise)
            cnt <= '0;
        else if (!cnt_sat)
            cnt <= cnt + CNT_W'(1);
    end

    assign cnt_sat  = (cnt == CNT_MAX);
    assign tmo_hit  = (cnt == TMO);
    assign cnt_p1   = {1'b0, cnt} + (CNT_W+1)'(1);
    assign per_val  = cnt_sat ? CNT_MAX : cnt_p1[CNT_W-1:0];
    assign per_good = !cnt_sat && (cnt_p1 >= PER_LO) && (cnt_p1 <= PER_HI);
    assign good_inc = good_q + GW'(1);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        period_d = Period;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        locked_d = Locked;
        stall_d  = Stall;
        case (state_q)
            ST_IDLE: begin
                // First edge only opens the measurement window.
                if (rise) begin
                    state_d = ST_MEASURE;
                    stall_d = 1'b0;
                    good_d  = '0;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_d = per_val;
                    vld_d    = 1'b1;
                    if (per_good) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LK) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    period_d = per_val;
                    vld_d    = 1'b1;
                    if (!per_good) begin
                        state_d  = ST_MEASURE;
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end else if (tmo_hit) begin
                    state_d  = ST_IDLE;
                    stall_d  = 1'b1;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                good_d   = '0;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_24M) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            good_q     <= '0;
            Period     <= '0;
            Period_vld <= 1'b0;
            Locked     <= 1'b0;
            Err        <= 1'b0;
            Stall      <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_q     <= good_d;
            Period     <= period_d;
            Period_vld <= vld_d;
            Locked     <= locked_d;
            Err        <= err_d;
            Stall      <= stall_d;
        end
    end

endmodule
